// File: rtl/updn_mod_counter.sv
// updn_mod_counter: modulo-MOD_VAL up/down counter with synchronous parallel load,
// terminal-count flags and a one-cycle wrap pulse.
// Optional build macro UPDN_CNT_SAT_EN adds a sat_mode input that lets the count
// saturate at either end of its range instead of wrapping.
// Default build (macro undefined): no sat_mode port, and the counter always wraps.

module updn_mod_counter #(
    parameter int WIDTH   = 4,
    parameter int MOD_VAL = 16,
    parameter int RST_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             count_enb,
    input  logic             updn_cnt,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
`ifdef UPDN_CNT_SAT_EN
    input  logic             sat_mode,
`endif
    output logic [WIDTH-1:0] data_out,
    output logic             at_max,
    output logic             at_zero,
    output logic             wrap_pulse
);

    // The top of the range is held as a WIDTH-bit constant. With MOD_VAL = 2**WIDTH
    // this is all ones, so no comparison or increment ever needs more than WIDTH bits.
    localparam logic [WIDTH-1:0] MAX_VAL   = WIDTH'(MOD_VAL - 1);
    localparam logic [WIDTH-1:0] RESET_VAL = WIDTH'(RST_VAL);
    localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

    logic             sat_active;
    logic [WIDTH-1:0] next_count;
    logic             next_wrap;

`ifdef UPDN_CNT_SAT_EN
    assign sat_active = sat_mode;
`else
    assign sat_active = 1'b0;
`endif

    // Terminal-count flags decode the register directly, adding no latency.
    assign at_max  = (data_out == MAX_VAL);
    assign at_zero = (data_out == '0);

    // Next-state selection in priority order load > count > hold (reset is in the register).
    // Wrapping is detected on the current value, so no carry or borrow ever leaves WIDTH bits.
    always_comb begin
        next_count = data_out;
        next_wrap  = 1'b0;
        if (load) begin
            if (load_data > MAX_VAL) begin
                next_count = MAX_VAL;
            end else begin
                next_count = load_data;
            end
        end else if (count_enb) begin
            if (updn_cnt) begin
                if (data_out == MAX_VAL) begin
                    if (!sat_active) begin
                        next_count = '0;
                        next_wrap  = 1'b1;
                    end
                end else begin
                    next_count = data_out + ONE;
                end
            end else begin
                if (data_out == '0) begin
                    if (!sat_active) begin
                        next_count = MAX_VAL;
                        next_wrap  = 1'b1;
                    end
                end else begin
                    next_count = data_out - ONE;
                end
            end
        end
    end

    // Count register and wrap pulse, both with synchronous reset overriding everything else.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out   <= RESET_VAL;
            wrap_pulse <= 1'b0;
        end else begin
            data_out   <= next_count;
            wrap_pulse <= next_wrap;
        end
    end

endmodule

// File: tb/tb_updn_mod_counter.sv
// tb_updn_mod_counter: directed tests for updn_mod_counter.
// dut  : WIDTH=4, MOD_VAL=10, RST_VAL=0 (main scenarios).
// dut2 : WIDTH=4, MOD_VAL=16, RST_VAL=15 (full-range arithmetic, non-zero reset value).
// Saturation scenarios are compiled only when UPDN_CNT_SAT_EN is defined.

module tb_updn_mod_counter;

    logic       clk;
    logic       rst;
    logic       count_enb;
    logic       updn_cnt;
    logic       load;
    logic [3:0] load_data;
`ifdef UPDN_CNT_SAT_EN
    logic       sat_mode;
`endif
    logic [3:0] data_out;
    logic       at_max;
    logic       at_zero;
    logic       wrap_pulse;

    logic       count_enb2;
    logic       updn_cnt2;
    logic       load2;
    logic [3:0] load_data2;
`ifdef UPDN_CNT_SAT_EN
    logic       sat_mode2;
`endif
    logic [3:0] data_out2;
    logic       at_max2;
    logic       at_zero2;
    logic       wrap_pulse2;

    int checks;
    int failures;

    updn_mod_counter #(.WIDTH(4), .MOD_VAL(10), .RST_VAL(0)) dut (
        .clk        (clk),
        .rst        (rst),
        .count_enb  (count_enb),
        .updn_cnt   (updn_cnt),
        .load       (load),
        .load_data  (load_data),
`ifdef UPDN_CNT_SAT_EN
        .sat_mode   (sat_mode),
`endif
        .data_out   (data_out),
        .at_max     (at_max),
        .at_zero    (at_zero),
        .wrap_pulse (wrap_pulse)
    );

    updn_mod_counter #(.WIDTH(4), .MOD_VAL(16), .RST_VAL(15)) dut2 (
        .clk        (clk),
        .rst        (rst),
        .count_enb  (count_enb2),
        .updn_cnt   (updn_cnt2),
        .load       (load2),
        .load_data  (load_data2),
`ifdef UPDN_CNT_SAT_EN
        .sat_mode   (sat_mode2),
`endif
        .data_out   (data_out2),
        .at_max     (at_max2),
        .at_zero    (at_zero2),
        .wrap_pulse (wrap_pulse2)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance past the next rising edge and settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset overrides load and count, a stray mid-cycle rst pulse is ignored,
    // and counting resumes from the reset value.
    task automatic test_reset();
        rst = 1'b1; load = 1'b1; load_data = 4'd5; count_enb = 1'b1; updn_cnt = 1'b1;
        tick();
        checks++;
        if (data_out !== 4'd0) begin
            failures++; $display("[TB] FAIL reset_data_out got=%0d want=0", data_out);
        end
        checks++;
        if (at_zero !== 1'b1 || at_max !== 1'b0 || wrap_pulse !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_flags got zero=%b max=%b wrap=%b want zero=1 max=0 wrap=0",
                     at_zero, at_max, wrap_pulse);
        end
        checks++;
        if (data_out2 !== 4'd15 || at_max2 !== 1'b1 || wrap_pulse2 !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_dut2 got=%0d max=%b wrap=%b want=15 max=1 wrap=0",
                     data_out2, at_max2, wrap_pulse2);
        end
        rst = 1'b0; load = 1'b0;
        tick();
        checks++;
        if (data_out !== 4'd1) begin
            failures++; $display("[TB] FAIL reset_resume got=%0d want=1", data_out);
        end
        count_enb = 1'b0;
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        tick();
        checks++;
        if (data_out !== 4'd1) begin
            failures++; $display("[TB] FAIL reset_glitch got=%0d want=1", data_out);
        end
    endtask

    // Up count 12 edges from 0: 1..9,0,1,2 with a single wrap pulse on the 0.
    task automatic test_up_count();
        int exp_val;
        load = 1'b1; load_data = 4'd0;
        tick();
        load = 1'b0; count_enb = 1'b1; updn_cnt = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            exp_val = (i + 1) % 10;
            checks++;
            if (data_out !== 4'(exp_val) || wrap_pulse !== (exp_val == 0) ||
                at_max !== (exp_val == 9) || at_zero !== (exp_val == 0)) begin
                failures++;
                $display("[TB] FAIL up_count[%0d] got=%0d wrap=%b max=%b zero=%b want=%0d wrap=%b max=%b zero=%b",
                         i, data_out, wrap_pulse, at_max, at_zero, exp_val,
                         exp_val == 0, exp_val == 9, exp_val == 0);
            end
        end
        count_enb = 1'b0;
    endtask

    // Down count 3 edges from 1: 0, 9, 8 with the wrap pulse on the 9.
    task automatic test_down_count();
        logic [3:0] exp_seq [3];
        exp_seq = '{4'd0, 4'd9, 4'd8};
        load = 1'b1; load_data = 4'd1;
        tick();
        load = 1'b0; count_enb = 1'b1; updn_cnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (data_out !== exp_seq[i] || wrap_pulse !== (exp_seq[i] == 4'd9) ||
                at_zero !== (exp_seq[i] == 4'd0)) begin
                failures++;
                $display("[TB] FAIL down_count[%0d] got=%0d wrap=%b zero=%b want=%0d wrap=%b zero=%b",
                         i, data_out, wrap_pulse, at_zero, exp_seq[i],
                         exp_seq[i] == 4'd9, exp_seq[i] == 4'd0);
            end
        end
        count_enb = 1'b0;
    endtask

    // Load clamps out-of-range data and beats a simultaneous wrapping count.
    task automatic test_load();
        load = 1'b1; load_data = 4'd14; count_enb = 1'b0;
        tick();
        checks++;
        if (data_out !== 4'd9 || at_max !== 1'b1) begin
            failures++; $display("[TB] FAIL load_clamp14 got=%0d max=%b want=9 max=1", data_out, at_max);
        end
        load_data = 4'd10;
        tick();
        checks++;
        if (data_out !== 4'd9) begin
            failures++; $display("[TB] FAIL load_clamp10 got=%0d want=9", data_out);
        end
        load_data = 4'd3; count_enb = 1'b1; updn_cnt = 1'b1;
        tick();
        checks++;
        if (data_out !== 4'd3 || wrap_pulse !== 1'b0) begin
            failures++;
            $display("[TB] FAIL load_over_count got=%0d wrap=%b want=3 wrap=0", data_out, wrap_pulse);
        end
        load = 1'b0; count_enb = 1'b0;
    endtask

    // Enable low holds the value regardless of direction.
    task automatic test_hold();
        load = 1'b1; load_data = 4'd7;
        tick();
        load = 1'b0; count_enb = 1'b0;
        for (int i = 0; i < 5; i++) begin
            updn_cnt = ~updn_cnt;
            tick();
            checks++;
            if (data_out !== 4'd7 || wrap_pulse !== 1'b0) begin
                failures++;
                $display("[TB] FAIL hold[%0d] got=%0d wrap=%b want=7 wrap=0", i, data_out, wrap_pulse);
            end
        end
    endtask

    // Wrap pulse is one cycle: a wrap followed by a hold edge and by a plain count edge.
    task automatic test_back_to_back();
        load = 1'b1; load_data = 4'd9;
        tick();
        load = 1'b0; count_enb = 1'b1; updn_cnt = 1'b1;
        tick();
        checks++;
        if (data_out !== 4'd0 || wrap_pulse !== 1'b1) begin
            failures++;
            $display("[TB] FAIL b2b_wrap got=%0d wrap=%b want=0 wrap=1", data_out, wrap_pulse);
        end
        count_enb = 1'b0;
        tick();
        checks++;
        if (data_out !== 4'd0 || wrap_pulse !== 1'b0) begin
            failures++;
            $display("[TB] FAIL b2b_hold got=%0d wrap=%b want=0 wrap=0", data_out, wrap_pulse);
        end
        count_enb = 1'b1; updn_cnt = 1'b0;
        tick();
        checks++;
        if (data_out !== 4'd9 || wrap_pulse !== 1'b1) begin
            failures++;
            $display("[TB] FAIL b2b_down_wrap got=%0d wrap=%b want=9 wrap=1", data_out, wrap_pulse);
        end
        tick();
        checks++;
        if (data_out !== 4'd8 || wrap_pulse !== 1'b0) begin
            failures++;
            $display("[TB] FAIL b2b_after got=%0d wrap=%b want=8 wrap=0", data_out, wrap_pulse);
        end
        count_enb = 1'b0;
    endtask

    // Modulus equal to 2**WIDTH: wraps at 15/0 without overflow.
    task automatic test_full_range();
        count_enb2 = 1'b1; updn_cnt2 = 1'b1;
        tick();
        checks++;
        if (data_out2 !== 4'd0 || wrap_pulse2 !== 1'b1 || at_zero2 !== 1'b1) begin
            failures++;
            $display("[TB] FAIL full_up_wrap got=%0d wrap=%b zero=%b want=0 wrap=1 zero=1",
                     data_out2, wrap_pulse2, at_zero2);
        end
        tick();
        checks++;
        if (data_out2 !== 4'd1 || wrap_pulse2 !== 1'b0) begin
            failures++;
            $display("[TB] FAIL full_up_next got=%0d wrap=%b want=1 wrap=0", data_out2, wrap_pulse2);
        end
        updn_cnt2 = 1'b0;
        tick();
        tick();
        checks++;
        if (data_out2 !== 4'd15 || wrap_pulse2 !== 1'b1 || at_max2 !== 1'b1) begin
            failures++;
            $display("[TB] FAIL full_down_wrap got=%0d wrap=%b max=%b want=15 wrap=1 max=1",
                     data_out2, wrap_pulse2, at_max2);
        end
        count_enb2 = 1'b0; load2 = 1'b1; load_data2 = 4'd12;
        tick();
        checks++;
        if (data_out2 !== 4'd12 || wrap_pulse2 !== 1'b0) begin
            failures++;
            $display("[TB] FAIL full_load got=%0d wrap=%b want=12 wrap=0", data_out2, wrap_pulse2);
        end
        load2 = 1'b0;
    endtask

`ifdef UPDN_CNT_SAT_EN
    // Saturation holds at both range ends with no wrap pulse.
    task automatic test_saturate();
        sat_mode = 1'b1;
        load = 1'b1; load_data = 4'd8;
        tick();
        load = 1'b0; count_enb = 1'b1; updn_cnt = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (data_out !== 4'd9 || wrap_pulse !== 1'b0) begin
                failures++;
                $display("[TB] FAIL sat_up[%0d] got=%0d wrap=%b want=9 wrap=0", i, data_out, wrap_pulse);
            end
        end
        count_enb = 1'b0; load = 1'b1; load_data = 4'd0;
        tick();
        load = 1'b0; count_enb = 1'b1; updn_cnt = 1'b0;
        tick();
        checks++;
        if (data_out !== 4'd0 || wrap_pulse !== 1'b0) begin
            failures++;
            $display("[TB] FAIL sat_down got=%0d wrap=%b want=0 wrap=0", data_out, wrap_pulse);
        end
        count_enb = 1'b0; sat_mode = 1'b0;
    endtask
`endif

    // Test sequence and summary.
    initial begin
        checks = 0; failures = 0;
        rst = 1'b1; count_enb = 1'b0; updn_cnt = 1'b0; load = 1'b0; load_data = 4'd0;
        count_enb2 = 1'b0; updn_cnt2 = 1'b0; load2 = 1'b0; load_data2 = 4'd0;
`ifdef UPDN_CNT_SAT_EN
        sat_mode = 1'b0; sat_mode2 = 1'b0;
`endif
        #1;
        $display("[TB] starting updn_mod_counter tests");
        test_reset();
        test_up_count();
        test_down_count();
        test_load();
        test_hold();
        test_back_to_back();
        test_full_range();
`ifdef UPDN_CNT_SAT_EN
        test_saturate();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/updn_mod_counter.md
UPDN_MOD_COUNTER -- requirements
Module: updn_mod_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, count register width in bits.
REQ-002 SHALL have parameter MOD_VAL, default 16, count modulus; legal range 2..2**WIDTH; count range 0..MOD_VAL-1.
REQ-003 SHALL have parameter RST_VAL, default 0, value loaded by reset; legal range 0..MOD_VAL-1.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous reset, active-high.
REQ-006 SHALL have port count_enb  input  1  count enable.
REQ-007 SHALL have port updn_cnt  input  1  direction: 1 = up, 0 = down; ignored when count_enb = 0.
REQ-008 SHALL have port load  input  1  synchronous parallel load request.
REQ-009 SHALL have port load_data  input  WIDTH  value to load.
REQ-010 SHALL have port sat_mode  input  1  1 = saturate at range ends, 0 = wrap; present only with UPDN_CNT_SAT_EN.
REQ-011 SHALL have port data_out  output  WIDTH  registered count value.
REQ-012 SHALL have port at_max  output  1  combinational, data_out == MOD_VAL-1.
REQ-013 SHALL have port at_zero  output  1  combinational, data_out == 0.
REQ-014 SHALL have port wrap_pulse  output  1  registered one-cycle pulse, set on the edge that wraps data_out.

Function
REQ-015 SHALL apply per-edge priority: rst > load > count_enb > hold.
REQ-016 SHALL on load set data_out to load_data next edge; load_data >= MOD_VAL clamps to MOD_VAL-1.
REQ-017 SHALL on load force wrap_pulse = 0 regardless of count_enb.
REQ-018 SHALL with count_enb = 1, updn_cnt = 1 increment data_out by 1 per edge; at MOD_VAL-1 next value is 0.
REQ-019 SHALL with count_enb = 1, updn_cnt = 0 decrement data_out by 1 per edge; at 0 next value is MOD_VAL-1.
REQ-020 SHALL assert wrap_pulse in the same cycle data_out shows the wrapped value (0 after up-wrap, MOD_VAL-1 after down-wrap), for exactly one cycle per wrap event.
REQ-021 SHALL keep wrap_pulse high on consecutive cycles only if consecutive wraps occur (e.g. MOD_VAL = 2 counting continuously).
REQ-022 SHALL hold data_out and drive wrap_pulse = 0 when count_enb = 0 and load = 0.
REQ-023 SHALL perform all arithmetic in WIDTH bits with no intermediate overflow for MOD_VAL = 2**WIDTH.
REQ-024 SHALL exhibit latency of one edge from any control input to data_out; at_max/at_zero follow data_out with zero added latency.

Reset
REQ-025 SHALL on rst = 1 at a rising edge set data_out = RST_VAL and wrap_pulse = 0, overriding load and count_enb.
REQ-026 SHALL have no asynchronous reset path; rst asserted between edges has no effect until the next edge.
REQ-027 SHALL resume counting from RST_VAL on the first edge after rst deasserts when count_enb = 1.

Configuration
REQ-028 SHALL, when macro UPDN_CNT_SAT_EN is defined, provide sat_mode; with sat_mode = 1, up at MOD_VAL-1 and down at 0 hold value with wrap_pulse = 0.
REQ-029 SHALL, when UPDN_CNT_SAT_EN is undefined, omit sat_mode and always wrap per REQ-018/019.
REQ-030 SHALL in both builds behave identically with sat_mode = 0.

Verification (WIDTH = 4, MOD_VAL = 10, RST_VAL = 0)
REQ-031 SHALL cover: rst = 1 with load = 1, load_data = 5, count_enb = 1 -> data_out = 0, at_zero = 1, wrap_pulse = 0.
REQ-032 SHALL cover: up count 12 edges from 0 -> sequence 1..9,0,1,2; wrap_pulse = 1 only in the cycle data_out = 0; at_max = 1 when data_out = 9.
REQ-033 SHALL cover: down count from 1, 3 edges -> 0, 9, 8; wrap_pulse = 1 only when data_out = 9.
REQ-034 SHALL cover: load = 1, load_data = 14 -> data_out = 9; load = 1 with count_enb = 1 at data_out = 9 up -> loaded value, wrap_pulse = 0.
REQ-035 SHALL cover: count_enb = 0 for 5 edges at data_out = 7, updn_cnt toggling -> data_out stays 7, wrap_pulse = 0.
REQ-036 SHALL cover, with UPDN_CNT_SAT_EN and sat_mode = 1: up 3 edges from 8 -> 9, 9, 9; down from 0 -> 0; wrap_pulse = 0 throughout.
